// File: rtl/psx_pad_poller.sv
// psx_pad_poller: console-side host for the PSX pad serial link.
// Each start runs one poll (0x01 0x42 0x00 0x00 0x00), latching the pad id
// and the 16 active-low button bits from the pad's reply.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | att high, waiting for start
// ATT_WAIT | att low, setup delay before the first psx_clk falling edge
// BIT_LO   | psx_clk low, cmd bit driven
// BIT_HI   | psx_clk high, pad data sampled on entry
// ACK_WAIT | byte done, waiting for the pad's ack pulse (with timeout)
// GAP      | idle psx_clk-high spacing before the next byte
// FINISH   | one cycle: done pulse, results latched, att high
// ABORT    | one cycle: timeout pulse, att high, results untouched
module psx_pad_poller #(
  parameter int CLK_DIV     = 8,
  parameter int ATT_SETUP   = 16,
  parameter int ACK_TIMEOUT = 256,
  parameter int BYTE_GAP    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        err,
  output logic [7:0]  pad_id,
  output logic [15:0] buttons,
  output logic        psx_clk,
  output logic        att,
  output logic        cmd,
  input  logic        data,
  input  logic        ack
);

  localparam int MAX_AB = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
  localparam int MAX_CD = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ATT_TC = CW'(ATT_SETUP - 1);
  localparam logic [CW-1:0] ACK_TC = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_TC = CW'(BYTE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, ATT_WAIT, BIT_LO, BIT_HI, ACK_WAIT, GAP, FINISH, ABORT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    rx;
  logic [7:0]    byte2, byte3, byte4;
  logic          ack_armed;
  logic          ack_seen;
  logic [1:0]    data_q;
  logic [1:0]    ack_q;
  logic          data_s;
  logic          ack_s;

  assign data_s = data_q[1];
  assign ack_s  = ack_q[1];

  // Command byte table: only the first two bytes carry non-zero commands.
  function automatic logic cmd_bit(input logic [2:0] bi, input logic [2:0] bt);
    logic [7:0] b;
    case (bi)
      3'd0:    b = 8'h01;
      3'd1:    b = 8'h42;
      default: b = 8'h00;
    endcase
    return b[bt];
  endfunction

  // Two-flop synchronizers for the pad's asynchronous data and ack lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 2'b11;
      ack_q  <= 2'b11;
    end else begin
      data_q <= {data_q[0], data};
      ack_q  <= {ack_q[0], ack};
    end
  end

  // Poll sequencer with registered pad-side and host-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      rx        <= 8'h00;
      byte2     <= 8'h00;
      byte3     <= 8'h00;
      byte4     <= 8'h00;
      ack_armed <= 1'b0;
      ack_seen  <= 1'b0;
      psx_clk   <= 1'b1;
      att       <= 1'b1;
      cmd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      pad_id    <= 8'hFF;
      buttons   <= 16'hFFFF;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      // Latch an ack low level any time after arming, so a pulse that
      // lands before ACK_WAIT is still honoured.
      if (ack_armed && !ack_s) ack_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            att      <= 1'b0;
            busy     <= 1'b1;
            err      <= 1'b0;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
            cnt      <= '0;
            state    <= ATT_WAIT;
          end
        end

        ATT_WAIT: begin
          if (cnt == ATT_TC) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            psx_clk <= 1'b0;
            cmd     <= cmd_bit(byte_idx, 3'd0);
            state   <= BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BIT_LO: begin
          if (cnt == DIV_TC) begin
            cnt     <= '0;
            psx_clk <= 1'b1;
            state   <= BIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BIT_HI: begin
          if (cnt == '0) begin
            rx <= {data_s, rx[7:1]};
            if (bit_idx == 3'd7 && byte_idx < 3'd4) begin
              ack_armed <= 1'b1;
              ack_seen  <= 1'b0;
            end
          end
          if (cnt == DIV_TC) begin
            cnt <= '0;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              psx_clk <= 1'b0;
              cmd     <= cmd_bit(byte_idx, bit_idx + 3'd1);
              state   <= BIT_LO;
            end else begin
              bit_idx <= 3'd0;
              cmd     <= 1'b1;
              case (byte_idx)
                3'd1:    byte2 <= rx;
                3'd2:    byte3 <= rx;
                3'd3:    byte4 <= rx;
                default: ;
              endcase
              if (byte_idx == 3'd4) begin
                // Last byte: rx already holds byte 5, so latch results now
                // and let FINISH present done/att for exactly one cycle.
                att     <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                pad_id  <= byte2;
                buttons <= {rx, byte4};
                err     <= (byte3 != 8'h5A);
                state   <= FINISH;
              end else begin
                state <= ACK_WAIT;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ACK_WAIT: begin
          if (ack_seen) begin
            ack_seen  <= 1'b0;
            ack_armed <= 1'b0;
            cnt       <= '0;
            state     <= GAP;
          end else if (cnt == ACK_TC) begin
            ack_seen  <= 1'b0;
            ack_armed <= 1'b0;
            cnt       <= '0;
            att       <= 1'b1;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            state     <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GAP_TC) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 3'd1;
            psx_clk  <= 1'b0;
            cmd      <= cmd_bit(byte_idx + 3'd1, 3'd0);
            state    <= BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FINISH, ABORT: begin
          cnt   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
